// File: rtl/alu_pipe_bcd.sv
// Two-stage ALU for multi-digit datapaths: stage 1 forms the binary result and
// nibble carries, stage 2 applies the per-digit decimal adjust and forms the flags.
module alu_pipe_bcd #(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic             phi2,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic             dec,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             hc
);
    localparam int D = WIDTH / 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_EOR  = 3'd3,
        OP_ORA  = 3'd4,
        OP_SR   = 3'd5,
        OP_SL   = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Returns {carry/borrow out, adjusted digit}; raw is a_i+b_i or a_i-b_i.
    function automatic logic [4:0] bcd_digit(input logic signed [6:0] raw,
                                             input logic k, input logic sub);
        logic signed [6:0] t;
        logic [3:0] r;
        if (sub) begin
            t = raw - $signed({6'b000000, k});
            r = t[3:0] + 4'd10;
            return (t < 7'sd0) ? {1'b1, r} : {1'b0, t[3:0]};
        end
        t = raw + $signed({6'b000000, k});
        r = t[3:0] + 4'd6;
        return (t > 7'sd9) ? {1'b1, r} : {1'b0, t[3:0]};
    endfunction

    op_e op_s;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] bin_sum;
    logic [D:0]       nib_c;
    logic [4:0]       nib_s;
    logic signed [6:0] ai, bi;

    logic              vld_p1_d, vld_p1_q;
    logic [WIDTH-1:0]  res_p1_d, res_p1_q;
    logic              c_p1_d, c_p1_q, v_p1_d, v_p1_q, hc_p1_d, hc_p1_q;
    logic              dec_p1_d, dec_p1_q, sub_p1_d, sub_p1_q, cin_p1_d, cin_p1_q;
    logic signed [6:0] dsum_p1_d [D];
    logic signed [6:0] dsum_p1_q [D];

    logic              out_valid_d, out_valid_q;
    logic [WIDTH-1:0]  result_d, result_q, dec_res;
    logic              flag_c_d, flag_c_q, flag_z_d, flag_z_q, flag_v_d, flag_v_q;
    logic              flag_n_d, flag_n_q, hc_d, hc_q, dec_c, chain;
    logic [4:0]        dig;

    assign op_s = op_e'(op);
    assign bb   = (op_s == OP_SUB) ? ~b : b;

    always_comb begin
        nib_c    = '0;
        nib_c[0] = cin;
        bin_sum  = '0;
        nib_s    = '0;
        for (int i = 0; i < D; i++) begin
            nib_s = {1'b0, a[4*i +: 4]} + {1'b0, bb[4*i +: 4]} + {4'b0000, nib_c[i]};
            bin_sum[4*i +: 4] = nib_s[3:0];
            nib_c[i+1] = nib_s[4];
        end
    end

    // Stage 1: binary result, carries and raw per-digit sums/differences
    always_comb begin
        vld_p1_d  = in_valid;
        res_p1_d  = res_p1_q;
        c_p1_d    = c_p1_q;
        v_p1_d    = v_p1_q;
        hc_p1_d   = hc_p1_q;
        dec_p1_d  = dec_p1_q;
        sub_p1_d  = sub_p1_q;
        cin_p1_d  = cin_p1_q;
        dsum_p1_d = dsum_p1_q;
        ai        = '0;
        bi        = '0;
        if (in_valid) begin
            c_p1_d   = cin;
            v_p1_d   = 1'b0;
            hc_p1_d  = 1'b0;
            dec_p1_d = 1'b0;
            sub_p1_d = (op_s == OP_SUB);
            cin_p1_d = cin;
            case (op_s)
                OP_ADD, OP_SUB: begin
                    res_p1_d = bin_sum;
                    c_p1_d   = nib_c[D];
                    v_p1_d   = (a[WIDTH-1] == bb[WIDTH-1]) && (bin_sum[WIDTH-1] != a[WIDTH-1]);
                    hc_p1_d  = nib_c[1];
                    dec_p1_d = dec && DECIMAL_EN;
                end
                OP_AND: res_p1_d = a & b;
                OP_EOR: res_p1_d = a ^ b;
                OP_ORA: res_p1_d = a | b;
                OP_SR: begin
                    res_p1_d = {cin, a[WIDTH-1:1]};
                    c_p1_d   = a[0];
                end
                OP_SL: begin
                    res_p1_d = {a[WIDTH-2:0], cin};
                    c_p1_d   = a[WIDTH-1];
                end
                default: res_p1_d = a;
            endcase
            for (int i = 0; i < D; i++) begin
                ai = $signed({3'b000, a[4*i +: 4]});
                bi = $signed({3'b000, b[4*i +: 4]});
                dsum_p1_d[i] = (op_s == OP_SUB) ? (ai - bi) : (ai + bi);
            end
        end
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            res_p1_q  <= '0;
            c_p1_q    <= 1'b0;
            v_p1_q    <= 1'b0;
            hc_p1_q   <= 1'b0;
            dec_p1_q  <= 1'b0;
            sub_p1_q  <= 1'b0;
            cin_p1_q  <= 1'b0;
            dsum_p1_q <= '{default: '0};
        end else if (!stall) begin
            vld_p1_q  <= vld_p1_d;
            res_p1_q  <= res_p1_d;
            c_p1_q    <= c_p1_d;
            v_p1_q    <= v_p1_d;
            hc_p1_q   <= hc_p1_d;
            dec_p1_q  <= dec_p1_d;
            sub_p1_q  <= sub_p1_d;
            cin_p1_q  <= cin_p1_d;
            dsum_p1_q <= dsum_p1_d;
        end
    end

    // Stage 2: decimal adjust ripple, flags, result hold across bubbles
    always_comb begin
        out_valid_d = vld_p1_q;
        result_d    = result_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        flag_v_d    = flag_v_q;
        flag_n_d    = flag_n_q;
        hc_d        = hc_q;
        dec_res     = res_p1_q;
        dec_c       = c_p1_q;
        chain       = sub_p1_q ? ~cin_p1_q : cin_p1_q;
        dig         = '0;
        if (DECIMAL_EN && dec_p1_q) begin
            for (int i = 0; i < D; i++) begin
                dig = bcd_digit(dsum_p1_q[i], chain, sub_p1_q);
                dec_res[4*i +: 4] = dig[3:0];
                chain = dig[4];
            end
            dec_c = sub_p1_q ? ~chain : chain;
        end
        if (vld_p1_q) begin
            result_d = dec_res;
            flag_c_d = dec_c;
            flag_z_d = (dec_res == '0);
            flag_v_d = v_p1_q;
            flag_n_d = dec_res[WIDTH-1];
            hc_d     = hc_p1_q;
        end
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            hc_q        <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            flag_v_q    <= flag_v_d;
            flag_n_q    <= flag_n_d;
            hc_q        <= hc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign flag_v    = flag_v_q;
    assign flag_n    = flag_n_q;
    assign hc        = hc_q;
endmodule

// File: tb/tb_alu_pipe_bcd.sv
// Directed bench for alu_pipe_bcd: 8-bit and 16-bit instances, hand-computed vectors.
module tb_alu_pipe_bcd;
    logic        phi2;
    logic        rst;
    logic        in_valid;
    logic        stall;
    logic [2:0]  op;
    logic        dec;
    logic [7:0]  a, b;
    logic [15:0] a16, b16;
    logic        cin;

    logic        out_valid, flag_c, flag_z, flag_v, flag_n, hc;
    logic [7:0]  result;
    logic        ov16, c16, z16, v16, n16, hc16;
    logic [15:0] res16;

    int n_checks = 0;
    int n_errors = 0;

    alu_pipe_bcd #(.WIDTH(8), .DECIMAL_EN(1'b1)) u_dut8 (
        .phi2(phi2), .rst(rst), .in_valid(in_valid), .stall(stall), .op(op), .dec(dec),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .hc(hc)
    );

    alu_pipe_bcd #(.WIDTH(16), .DECIMAL_EN(1'b1)) u_dut16 (
        .phi2(phi2), .rst(rst), .in_valid(in_valid), .stall(stall), .op(op), .dec(dec),
        .a(a16), .b(b16), .cin(cin), .out_valid(ov16), .result(res16),
        .flag_c(c16), .flag_z(z16), .flag_v(v16), .flag_n(n16), .hc(hc16)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    typedef struct packed {
        logic [2:0] op;
        logic       dec;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] r;
        logic       c, z, v, n, h;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge phi2);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic d, input logic [7:0] x,
                         input logic [7:0] y, input logic c);
        op = o; dec = d; a = x; b = y; cin = c; in_valid = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] r, input logic c,
                             input logic z, input logic v, input logic n, input logic h);
        check({tag, "_ov"}, 32'(out_valid), 32'(1'b1));
        check({tag, "_res"}, 32'(result), 32'(r));
        check({tag, "_c"}, 32'(flag_c), 32'(c));
        check({tag, "_z"}, 32'(flag_z), 32'(z));
        check({tag, "_v"}, 32'(flag_v), 32'(v));
        check({tag, "_n"}, 32'(flag_n), 32'(n));
        check({tag, "_hc"}, 32'(hc), 32'(h));
    endtask

    task automatic run_vec(input int i);
        string tag;
        tag = $sformatf("v%0d", i);
        drive(vecs[i].op, vecs[i].dec, vecs[i].a, vecs[i].b, vecs[i].cin);
        tick();
        in_valid = 1'b0;
        check({tag, "_early"}, 32'(out_valid), 32'(1'b0));
        tick();
        check_out(tag, vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].n, vecs[i].h);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //                op    dec   a      b      cin   r      c     z     v     n     h
        vecs[0]  = '{3'd0, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{3'd0, 1'b1, 8'h58, 8'h46, 1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 1'b1, 8'h12, 8'h21, 1'b1, 8'h91, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{3'd1, 1'b0, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'd0, 1'b1, 8'h99, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd2, 1'b1, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 1'b0, 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd4, 1'b0, 8'h80, 8'h01, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'd7, 1'b0, 8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3'd1, 1'b0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd1, 1'b1, 8'h00, 8'h01, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'd0, 1'b1, 8'h09, 8'h09, 1'b0, 8'h18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; op = 3'd0; dec = 1'b0;
        a = 8'h00; b = 8'h00; a16 = 16'h0000; b16 = 16'h0000; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ov", 32'(out_valid), 32'(1'b0));
        check("rst_res", 32'(result), 32'(8'h00));
        check("rst_flags", 32'({flag_c, flag_z, flag_v, flag_n, hc}), 32'(5'b00000));

        for (int i = 0; i < 12; i++) run_vec(i);

        // 16-bit decimal ripple across all four digits
        drive(3'd0, 1'b1, 8'h00, 8'h00, 1'b0);
        a16 = 16'h9999; b16 = 16'h0001;
        tick();
        in_valid = 1'b0;
        tick();
        check("w16_ov", 32'(ov16), 32'(1'b1));
        check("w16_res", 32'(res16), 32'(16'h0000));
        check("w16_c", 32'(c16), 32'(1'b1));
        check("w16_z", 32'(z16), 32'(1'b1));
        check("w16_vnh", 32'({v16, n16, hc16}), 32'(3'b000));
        a16 = 16'h0000; b16 = 16'h0000;
        tick();

        // back-to-back shifts
        drive(3'd5, 1'b0, 8'h81, 8'h00, 1'b1);
        tick();
        drive(3'd6, 1'b0, 8'h81, 8'h00, 1'b0);
        tick();
        in_valid = 1'b0;
        check_out("sr", 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("sl", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("b2b_bubble", 32'(out_valid), 32'(1'b0));

        // stall for three cycles after issue, with a dropped in_valid pulse
        drive(3'd0, 1'b0, 8'h10, 8'h20, 1'b0);
        tick();
        in_valid = 1'b0; stall = 1'b1;
        tick();
        check("stall_ov1", 32'(out_valid), 32'(1'b0));
        drive(3'd0, 1'b0, 8'h44, 8'h44, 1'b0);
        tick();
        in_valid = 1'b0;
        check("stall_ov2", 32'(out_valid), 32'(1'b0));
        tick();
        check("stall_ov3", 32'(out_valid), 32'(1'b0));
        stall = 1'b0;
        tick();
        check("stall_ov", 32'(out_valid), 32'(1'b1));
        check("stall_res", 32'(result), 32'(8'h30));
        tick();
        check("stall_drop", 32'(out_valid), 32'(1'b0));
        check("stall_hold", 32'(result), 32'(8'h30));

        // reset while an op is in flight
        run_vec(0);
        drive(3'd0, 1'b0, 8'h55, 8'h22, 1'b0);
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_ov", 32'(out_valid), 32'(1'b0));
        check("mrst_res", 32'(result), 32'(8'h00));
        check("mrst_flags", 32'({flag_c, flag_z, flag_v, flag_n, hc}), 32'(5'b00000));
        tick();
        check("mrst_discard", 32'(out_valid), 32'(1'b0));
        drive(3'd0, 1'b0, 8'h01, 8'h02, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check_out("post_rst", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
